// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in/serial-out shifter with valid/ready load,
// bit counter and end-of-frame pulse. Rev 1.0
`default_nettype none

module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             serial_i,
  output logic             q_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sr_shift;
  logic             sr_out;
  logic             last_tick;
  logic             accept;

  // Fill bit enters at the end opposite to the one being retired.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr_q[WIDTH-2:0], serial_i};
      assign sr_out   = sr_q[WIDTH-1];
    end else begin : g_lsb_first
      assign sr_shift = {serial_i, sr_q[WIDTH-1:1]};
      assign sr_out   = sr_q[0];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    last_tick = (state_q == S_SHIFT) && (cnt_q == LAST) && tick_i;
    ready_o   = (state_q == S_IDLE) || last_tick;
    accept    = valid_i && ready_o;
    busy_o    = (state_q == S_SHIFT);
    q_o       = (state_q == S_SHIFT) ? sr_out : IDLE_LEVEL;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d    = data_i;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_tick) begin
          done_d = 1'b1;
          // Back-to-back load on the last-bit edge keeps the line gap-free.
          if (accept) begin
            sr_d  = data_i;
            cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick_i) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: table-driven vectors plus directed sequences.
`default_nettype none

module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, valid, serial, valid_c;
  logic [3:0] data;
  logic [7:0] data_c;
  logic ready_a, q_a, busy_a, done_a;
  logic ready_b, q_b, busy_b, done_b;
  logic ready_c, q_c, busy_c, done_c;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .data_i(data), .valid_i(valid),
    .ready_o(ready_a), .serial_i(serial), .q_o(q_a), .busy_o(busy_a), .done_o(done_a));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .data_i(data), .valid_i(valid),
    .ready_o(ready_b), .serial_i(serial), .q_o(q_b), .busy_o(busy_b), .done_o(done_b));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .data_i(data_c), .valid_i(valid_c),
    .ready_o(ready_c), .serial_i(serial), .q_o(q_c), .busy_o(busy_c), .done_o(done_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       tick, valid, serial;
    logic [3:0] data;
    logic       qa, qb, busy, ready, done;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    logic [3:0] pat;
    int         dcnt;

    // tick, valid, serial, data, q_a, q_b, busy, ready, done
    // LSB/MSB-first single frame, tick every clk, data 1011
    tbl[0]  = 12'b1_1_0_1011_0_1_0_1_0;
    tbl[1]  = 12'b1_0_0_1011_1_1_1_0_0;
    tbl[2]  = 12'b1_0_0_0000_0_1_1_0_0;
    tbl[3]  = 12'b1_0_0_0000_1_0_1_0_0;
    tbl[4]  = 12'b1_0_0_0000_1_1_1_1_0;
    tbl[5]  = 12'b1_0_0_0000_0_1_0_1_1;
    tbl[6]  = 12'b0_0_0_0000_0_1_0_1_0;
    // back-to-back 1100 then 0011; valid held while ready low must be ignored
    tbl[7]  = 12'b1_1_0_1100_0_1_0_1_0;
    tbl[8]  = 12'b1_1_0_0011_1_0_1_0_0;
    tbl[9]  = 12'b1_1_0_0011_1_0_1_0_0;
    tbl[10] = 12'b1_1_0_0011_0_1_1_0_0;
    tbl[11] = 12'b1_1_0_0011_0_1_1_1_0;
    tbl[12] = 12'b1_0_0_0011_0_1_1_0_1;
    tbl[13] = 12'b1_0_0_0000_0_1_1_0_0;
    tbl[14] = 12'b1_0_0_0000_1_0_1_0_0;
    tbl[15] = 12'b1_0_0_0000_1_0_1_1_0;
    tbl[16] = 12'b0_0_0_0000_0_1_0_1_1;
    tbl[17] = 12'b0_0_0_0000_0_1_0_1_0;

    rst = 1'b1; tick = 1'b0; valid = 1'b0; serial = 1'b0; data = '0;
    valid_c = 1'b0; data_c = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst q_a", q_a, 1'b0);
    chk("rst q_b idle level", q_b, 1'b1);
    chk("rst busy", busy_a, 1'b0);
    chk("rst ready", ready_a, 1'b1);
    chk("rst done", done_a, 1'b0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      tick = tbl[i].tick; valid = tbl[i].valid; serial = tbl[i].serial; data = tbl[i].data;
      #1;
      chk($sformatf("vec%0d q_a", i), q_a, tbl[i].qa);
      chk($sformatf("vec%0d q_b", i), q_b, tbl[i].qb);
      chk($sformatf("vec%0d busy_a", i), busy_a, tbl[i].busy);
      chk($sformatf("vec%0d busy_b", i), busy_b, tbl[i].busy);
      chk($sformatf("vec%0d ready_a", i), ready_a, tbl[i].ready);
      chk($sformatf("vec%0d ready_b", i), ready_b, tbl[i].ready);
      chk($sformatf("vec%0d done_a", i), done_a, tbl[i].done);
      chk($sformatf("vec%0d done_b", i), done_b, tbl[i].done);
    end

    // Slow tick: one tick every 4 clks, each bit held for the full interval
    pat = 4'b1011;
    @(negedge clk);
    tick = 1'b0; valid = 1'b1; data = pat;
    #1 chk("slow accept ready", ready_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        valid = 1'b0; data = '0; tick = (j == 3);
        #1;
        chk($sformatf("slow b%0d c%0d q_a", i, j), q_a, pat[3-i]);
        chk($sformatf("slow b%0d c%0d q_b", i, j), q_b, pat[i]);
        chk($sformatf("slow b%0d c%0d busy", i, j), busy_a, 1'b1);
        chk($sformatf("slow b%0d c%0d done", i, j), done_a, 1'b0);
        chk($sformatf("slow b%0d c%0d ready", i, j), ready_a, (i == 3 && j == 3));
      end
    end
    @(negedge clk);
    tick = 1'b0;
    #1;
    chk("slow end done", done_a, 1'b1);
    chk("slow end busy", busy_a, 1'b0);
    chk("slow end ready", ready_a, 1'b1);
    chk("slow end q_a", q_a, 1'b0);
    @(negedge clk);
    #1 chk("slow done clears", done_a, 1'b0);

    // Asynchronous reset in the middle of bit 2 aborts the frame
    @(negedge clk);
    tick = 1'b1; valid = 1'b1; data = 4'b1111;
    @(negedge clk);
    valid = 1'b0;
    #1 chk("abort bit0 q_a", q_a, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort q_a", q_a, 1'b0);
    chk("abort q_b", q_b, 1'b1);
    chk("abort busy", busy_a, 1'b0);
    chk("abort ready", ready_a, 1'b1);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("abort no done %0d", k), done_a | done_b, 1'b0);
    end
    pat = 4'b0101;
    @(negedge clk);
    valid = 1'b1; data = pat;
    #1 chk("post-abort ready", ready_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b0;
      #1;
      chk($sformatf("post-abort b%0d q_a", i), q_a, pat[3-i]);
      chk($sformatf("post-abort b%0d q_b", i), q_b, pat[i]);
      chk($sformatf("post-abort b%0d done", i), done_a, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("post-abort done_a", done_a, 1'b1);
    chk("post-abort done_b", done_b, 1'b1);

    // WIDTH=8, fill bit 1, word 00: fill never reaches the output within a frame
    @(negedge clk);
    tick = 1'b1; serial = 1'b1; valid_c = 1'b1; data_c = 8'h00;
    #1 chk("w8 accept ready", ready_c, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      valid_c = 1'b0;
      #1;
      chk($sformatf("w8 b%0d q_c", i), q_c, 1'b0);
      chk($sformatf("w8 b%0d busy_c", i), busy_c, 1'b1);
      chk($sformatf("w8 b%0d cnt", i), u_c.cnt_q, i);
      chk($sformatf("w8 b%0d ready_c", i), ready_c, (i == 7));
      if (done_c) dcnt++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("w8 tail%0d done_c", k), done_c, (k == 0));
      chk($sformatf("w8 tail%0d busy_c", k), busy_c, 1'b0);
      if (done_c) dcnt++;
    end
    chk("w8 done pulse count", dcnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, bit counter and end-of-frame flag.
- Successor to the fixed 4-bit load/shift chain. Generalised in width and bit order; adds frame sequencing and back-to-back loading.
- Shift rate is set by a single-cycle enable tick, e.g. from the frequency divider. The clock is never gated.

Parameters:
- WIDTH, 4: word width in bits. Must be >= 2.
- MSB_FIRST, 1: 1 shifts data_i[WIDTH-1] out first; 0 shifts data_i[0] out first.
- IDLE_LEVEL, 0: value driven on q_o while idle.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- tick_i  in  1  shift enable, sampled on clk_i; one bit period = one tick.
- data_i  in  WIDTH  parallel word, sampled only on handshake.
- valid_i  in  1  producer has a word on data_i.
- ready_o  out  1  block can accept a word this cycle.
- serial_i  in  1  fill bit shifted into the vacated end (cascade input).
- q_o  out  1  serial output.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-clk pulse when the last bit of a frame is retired.

Behaviour:
- Internal state: shift register sr[WIDTH-1:0], counter cnt of $clog2(WIDTH) bits, FSM {IDLE, SHIFT}.
- Reset (async, any time): FSM=IDLE, sr=0, cnt=0, done_o=0. After reset, busy_o=0, ready_o=1, q_o=IDLE_LEVEL.
- A reset mid-frame aborts the frame. done_o does not pulse for the aborted frame.
- Handshake: a word is accepted on a clk edge when valid_i & ready_o. Acceptance happens on that edge and does not need tick_i.
- ready_o is combinational: (FSM==IDLE) | (FSM==SHIFT & cnt==WIDTH-1 & tick_i).
- IDLE:
  - q_o=IDLE_LEVEL, busy_o=0.
  - On accept: sr<=data_i, cnt<=0, FSM<=SHIFT.
  - tick_i is ignored.
- SHIFT:
  - busy_o=1. q_o = sr[WIDTH-1] if MSB_FIRST, else sr[0].
  - q_o is combinational from sr, so the first bit appears the cycle after accept.
- tick_i in SHIFT with cnt < WIDTH-1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], serial_i}.
  - MSB_FIRST=0: sr <= {serial_i, sr[WIDTH-1:1]}.
  - cnt <= cnt+1.
- tick_i in SHIFT with cnt == WIDTH-1 (last bit):
  - done_o<=1 for exactly one clk.
  - If valid_i: accept, sr<=data_i, cnt<=0, stay in SHIFT. No idle gap between frames.
  - Else: FSM<=IDLE.
- No tick_i in SHIFT: sr, cnt and q_o hold. Each bit stays on q_o for exactly one tick interval.
- Latency: first bit on q_o 1 clk after accept. Frame length = WIDTH ticks. done_o is asserted in the clk after the WIDTH-th tick.
- valid_i while ready_o=0 is ignored. data_i changes during a frame have no effect. The producer must hold valid_i and data_i until ready_o.
- tick_i tied high: one bit per clk. Back-to-back frames are continuous, one word every WIDTH clks.
- cnt never exceeds WIDTH-1. No wrap occurs outside the last-bit rule.
- done_o is registered and clears on the next clk.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, tick every 4 clks, accept 4'b1011, valid_i then low -> q_o 1,0,1,1, each held 4 clks; done_o one-clk pulse after the 4th tick; then IDLE, q_o=0, ready_o=1.
2. MSB_FIRST=0, tick_i=1, accept 4'b1011 -> q_o 1,1,0,1 on consecutive clks; busy_o high exactly 4 clks.
3. tick_i=1, valid_i held with 4'b1100 then 4'b0011 -> second word accepted on the last-bit edge; q_o 1,1,0,0,0,0,1,1 with no gap; two done_o pulses 4 clks apart.
4. Accept 4'b1111, assert rst_i asynchronously mid-bit 2 -> q_o=IDLE_LEVEL, busy_o=0, ready_o=1 immediately; no done_o; a new frame 4'b0101 then serializes correctly.
5. During a frame, change data_i and pulse valid_i while ready_o=0 -> original frame unaffected; the new word is accepted only at the last-bit edge or in IDLE.
6. WIDTH=8, serial_i=1, accept 8'h00, tick_i=1 -> q_o 0×8 and cnt reaches 7; done_o pulses once.
